// File: rtl/cell_update_renderer.sv
// rtl/cell_update_renderer.sv - queues grid cell updates and paints each cell over an 8080-style LCD bus
module cell_update_renderer #(
    parameter int CELL_PX    = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       diff,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       ready,
    output logic       busy,
    output logic       overflow,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_wr_n,
    output logic [7:0] lcd_data
);

    localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]       CELL_W   = 16'(CELL_PX);
    localparam logic [15:0]       LAST_PIX = 16'(CELL_PX * CELL_PX - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CASET, S_PASET, S_RAMWR, S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic              phase_q, phase_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       pix_q, pix_d;
    logic [15:0]       x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [15:0]       colour_q, colour_d;
    logic [10:0]       mem_q [FIFO_DEPTH];
    logic [10:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              cs_n_q, cs_n_d, dc_q, dc_d, wr_n_q, wr_n_d;
    logic [7:0]        data_q, data_d;

    logic              push, pop, active;
    logic [10:0]       head;
    logic [3:0]        head_x, head_y;
    logic [2:0]        head_obj;

    function automatic logic [15:0] obj_colour(input logic [2:0] c);
        case (c)
            3'd1:    obj_colour = 16'hFFE0;
            3'd2:    obj_colour = 16'h07E0;
            3'd3:    obj_colour = 16'hF800;
            3'd4:    obj_colour = 16'h001F;
            default: obj_colour = 16'h0000;
        endcase
    endfunction

    // A full queue refuses the update even if the renderer pops in the same cycle
    assign push     = diff && (count_q != FULL_CNT);
    assign pop      = (state_q == S_LOAD);
    assign head     = mem_q[rd_ptr_q];
    assign head_x   = head[10:7];
    assign head_y   = head[6:3];
    assign head_obj = head[2:0];

    assign ready    = (count_q != FULL_CNT);
    assign busy     = (state_q != S_IDLE) || (count_q != '0);
    assign overflow = overflow_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_dc   = dc_q;
    assign lcd_wr_n = wr_n_q;
    assign lcd_data = data_q;

    // State register, FIFO storage and registered bus outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            idx_q      <= '0;
            pix_q      <= '0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            colour_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            cs_n_q     <= 1'b1;
            dc_q       <= 1'b1;
            wr_n_q     <= 1'b1;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            pix_q      <= pix_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            colour_q   <= colour_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            cs_n_q     <= cs_n_d;
            dc_q       <= dc_d;
            wr_n_q     <= wr_n_d;
            data_q     <= data_d;
        end
    end

    // Next-state: walk the command/data byte sequence, two clocks per byte
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        pix_d   = pix_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (head_y > 4'd11) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CASET;
                    phase_d = 1'b0;
                    idx_d   = '0;
                    pix_d   = '0;
                end
            end
            S_CASET, S_PASET: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (idx_q == 3'd4) begin
                        state_d = (state_q == S_CASET) ? S_PASET : S_RAMWR;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_RAMWR: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = S_FILL;
                    idx_d   = '0;
                    pix_d   = '0;
                end
            end
            S_FILL: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!idx_q[0]) begin
                        idx_d = 3'd1;
                    end else begin
                        idx_d = '0;
                        if (pix_q == LAST_PIX) state_d = S_IDLE;
                        else                   pix_d   = pix_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Queue bookkeeping and window coordinates latched when an entry is popped
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (diff && (count_q == FULL_CNT));
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        colour_d   = colour_q;
        if (push) begin
            mem_d[wr_ptr_q] = {x, y, obj_code};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
        if (pop) begin
            x0_d     = 16'(head_x) * CELL_W;
            x1_d     = x0_d + CELL_W - 16'd1;
            y0_d     = 16'(head_y) * CELL_W;
            y1_d     = y0_d + CELL_W - 16'd1;
            colour_d = obj_colour(head_obj);
        end
    end

    // Output decode from the next state so every lcd_* pin comes straight from a flop
    always_comb begin
        active = (state_d == S_CASET) || (state_d == S_PASET) ||
                 (state_d == S_RAMWR) || (state_d == S_FILL);
        cs_n_d = !active;
        wr_n_d = !(active && !phase_d);
        dc_d   = 1'b1;
        data_d = 8'h00;
        case (state_d)
            S_CASET: begin
                case (idx_d)
                    3'd0:    begin dc_d = 1'b0; data_d = 8'h2A; end
                    3'd1:    data_d = x0_q[15:8];
                    3'd2:    data_d = x0_q[7:0];
                    3'd3:    data_d = x1_q[15:8];
                    default: data_d = x1_q[7:0];
                endcase
            end
            S_PASET: begin
                case (idx_d)
                    3'd0:    begin dc_d = 1'b0; data_d = 8'h2B; end
                    3'd1:    data_d = y0_q[15:8];
                    3'd2:    data_d = y0_q[7:0];
                    3'd3:    data_d = y1_q[15:8];
                    default: data_d = y1_q[7:0];
                endcase
            end
            S_RAMWR: begin
                dc_d   = 1'b0;
                data_d = 8'h2C;
            end
            S_FILL: begin
                data_d = idx_d[0] ? colour_q[7:0] : colour_q[15:8];
            end
            default: begin
                dc_d   = 1'b1;
                data_d = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_cell_update_renderer.sv
// tb/tb_cell_update_renderer.sv - randomized self-checking bench for cell_update_renderer
module tb_cell_update_renderer;

    logic       clk = 1'b0;
    logic       rst;
    logic       diff;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic       ready, busy, overflow, lcd_cs_n, lcd_dc, lcd_wr_n;
    logic [7:0] lcd_data;

    int checks = 0;
    int passed = 0;

    logic [9:0] cap_q[$];
    logic [9:0] exp_q[$];
    int         cs_low_cnt = 0;
    int         exp_cells  = 0;
    bit         ovf_m      = 1'b0;

    cell_update_renderer #(.CELL_PX(20), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .diff(diff), .x(x), .y(y), .obj_code(obj_code),
        .ready(ready), .busy(busy), .overflow(overflow),
        .lcd_cs_n(lcd_cs_n), .lcd_dc(lcd_dc), .lcd_wr_n(lcd_wr_n), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bus monitor: one record per write strobe, plus a count of chip-select-low cycles
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (lcd_wr_n === 1'b0) cap_q.push_back({lcd_cs_n, lcd_dc, lcd_data});
            if (lcd_cs_n === 1'b0) cs_low_cnt++;
        end
    end

    function automatic logic [15:0] ref_colour(input logic [2:0] c);
        case (c)
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07E0;
            3'd3:    return 16'hF800;
            3'd4:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Expected bus bytes for one accepted update, as {cs_n, dc, data}
    task automatic model_cell(input logic [3:0] cx, input logic [3:0] cy, input logic [2:0] co);
        logic [15:0] x0, x1, y0, y1, col;
        if (cy > 4'd11) return;
        x0  = 16'(int'(cx) * 20);
        x1  = 16'(int'(cx) * 20 + 19);
        y0  = 16'(int'(cy) * 20);
        y1  = 16'(int'(cy) * 20 + 19);
        col = ref_colour(co);
        exp_q.push_back({2'b00, 8'h2A});
        exp_q.push_back({2'b01, x0[15:8]});
        exp_q.push_back({2'b01, x0[7:0]});
        exp_q.push_back({2'b01, x1[15:8]});
        exp_q.push_back({2'b01, x1[7:0]});
        exp_q.push_back({2'b00, 8'h2B});
        exp_q.push_back({2'b01, y0[15:8]});
        exp_q.push_back({2'b01, y0[7:0]});
        exp_q.push_back({2'b01, y1[15:8]});
        exp_q.push_back({2'b01, y1[7:0]});
        exp_q.push_back({2'b00, 8'h2C});
        for (int p = 0; p < 400; p++) begin
            exp_q.push_back({2'b01, col[15:8]});
            exp_q.push_back({2'b01, col[7:0]});
        end
        exp_cells++;
    endtask

    // Presents one update for one clock; called and returns at a falling edge
    task automatic send(input logic [3:0] cx, input logic [3:0] cy, input logic [2:0] co);
        diff     = 1'b1;
        x        = cx;
        y        = cy;
        obj_code = co;
        if (ready === 1'b1) model_cell(cx, cy, co);
        else                ovf_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_streams();
        cap_q.delete();
        exp_q.delete();
        cs_low_cnt = 0;
        exp_cells  = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL %s drain: busy=%b after %0d cycles, required 0", name, busy, n);
        else passed++;
    endtask

    task automatic wait_bytes(input string name, input int nbytes);
        int n = 0;
        while (cap_q.size() < nbytes && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cap_q.size() < nbytes) $display("FAIL %s progress: %0d bytes seen, required %0d", name, cap_q.size(), nbytes);
        else passed++;
    endtask

    task automatic check_stream(input string name);
        int bad = -1;
        int n;
        checks++;
        if (cap_q.size() != exp_q.size())
            $display("FAIL %s byte count: got %0d, required %0d", name, cap_q.size(), exp_q.size());
        else passed++;
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0)
            $display("FAIL %s bytes: index %0d got {cs_n,dc,data}=%h, required %h", name, bad, cap_q[bad], exp_q[bad]);
        else passed++;
        checks++;
        if (cs_low_cnt != exp_cells * 1622)
            $display("FAIL %s cs_n low cycles: got %0d, required %0d", name, cs_low_cnt, exp_cells * 1622);
        else passed++;
    endtask

    task automatic check_ovf(input string name);
        checks++;
        if (overflow !== ovf_m) $display("FAIL %s overflow: got %b, required %b", name, overflow, ovf_m);
        else passed++;
    endtask

    task automatic check_idle_pins(input string name);
        logic [13:0] got;
        got = {ready, busy, overflow, lcd_cs_n, lcd_dc, lcd_wr_n, lcd_data};
        checks++;
        if (got !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00})
            $display("FAIL %s pins {ready,busy,ovf,cs_n,dc,wr_n,data}: got %b, required 1_0_0_1_1_1_00000000", name, got);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; diff = 1'b0; x = '0; y = '0; obj_code = '0;
        repeat (3) @(negedge clk);
        check_idle_pins("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_pins("after reset");
    endtask

    task automatic test_single();
        int k;
        clear_streams();
        send(4'd3, 4'd2, 3'd1);
        diff = 1'b0;
        k = 1;
        while (lcd_wr_n !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 3) $display("FAIL latency: first write strobe after edge E+%0d, required E+2", k - 1);
        else passed++;
        wait_idle("single");
        check_stream("single");
    endtask

    task automatic test_corner();
        clear_streams();
        send(4'd15, 4'd11, 3'd4);
        diff = 1'b0;
        wait_idle("corner");
        check_stream("corner");
    endtask

    task automatic test_obj7_invalid();
        clear_streams();
        send(4'd5, 4'd12, 3'd2);
        diff = 1'b0;
        wait_idle("row12");
        check_stream("row12");
        clear_streams();
        send(4'd0, 4'd0, 3'd7);
        diff = 1'b0;
        wait_idle("obj7");
        check_stream("obj7");
    endtask

    task automatic test_random();
        int gap;
        clear_streams();
        for (int i = 0; i < 10; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 13)), 3'($urandom_range(0, 7)));
            gap = $urandom_range(0, 4);
            if (gap >= 3) gap = $urandom_range(100, 1700);
            if (gap > 0) begin
                diff = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        diff = 1'b0;
        wait_idle("random");
        check_stream("random");
        check_ovf("random");
    endtask

    task automatic test_overflow();
        clear_streams();
        send(4'd1, 4'd1, 3'd2);
        diff = 1'b0;
        wait_bytes("overflow", 12);
        send(4'd2, 4'd2, 3'd1);
        send(4'd3, 4'd3, 3'd3);
        send(4'd4, 4'd4, 3'd4);
        send(4'd5, 4'd5, 3'd0);
        checks++;
        if (ready !== 1'b0) $display("FAIL full ready: got %b, required 0", ready);
        else passed++;
        send(4'd6, 4'd6, 3'd1);
        send(4'd6, 4'd6, 3'd1);
        diff = 1'b0;
        check_ovf("overflow");
        wait_idle("overflow");
        check_stream("overflow");
    endtask

    task automatic test_reset_mid();
        clear_streams();
        send(4'd8, 4'd3, 3'd3);
        diff = 1'b0;
        wait_bytes("reset mid", 40);
        send(4'd9, 4'd4, 3'd1);
        diff = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_idle_pins("async reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_streams();
        ovf_m = 1'b0;
        repeat (200) @(negedge clk);
        check_stream("after reset");
        check_idle_pins("after reset idle");
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_obj7_invalid();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
